// File: rtl/mem_access_unit_if.sv
// Bus bundle between the EX stage, the memory access unit, the WB stage and the SRAM.
// The slave modport is the access unit's view; master is the surrounding pipeline/SRAM view.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  logic        mem_cs;
  logic        mem_oe;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  resp_ready, mem_dout,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_cs, mem_oe, mem_we, mem_addr, mem_din
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output resp_ready, mem_dout,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_cs, mem_oe, mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit between EX and WB driving a simple SRAM with big-endian byte lanes.
// Define MISALIGN_TRAP_EN to fault misaligned/illegal accesses instead of aligning them.
module mem_access_unit #(
  parameter int unsigned SRAM_WAIT = 0
) (
  input  logic             clk,
  input  logic             rst,
  mem_access_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, RSP = 2'd3} state_e;

  localparam logic [1:0] SZ_BYTE   = 2'b00;
  localparam logic [1:0] SZ_HALF   = 2'b01;
  localparam logic [1:0] SZ_WORD   = 2'b10;
  localparam logic [2:0] WAIT_LAST = 3'(SRAM_WAIT);

  state_e      state_q, state_d;
  logic [2:0]  wait_cnt_q, wait_cnt_d;

  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] wdata_q, wdata_d;

  logic        mem_cs_q, mem_cs_d;
  logic        mem_oe_q, mem_oe_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_din_q, mem_din_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

  logic        accept;
  logic        rd_last;
  logic        fault;
  logic [1:0]  size_eff;
  logic [1:0]  off_eff;
  logic [7:0]  byte_val;
  logic [15:0] half_val;
  logic [31:0] load_val;
  logic [31:0] merged;

  assign accept  = (state_q == IDLE) && bus.req_valid;
  assign rd_last = (state_q == RD) && (wait_cnt_q == WAIT_LAST);

  always_comb begin : req_decode
    size_eff = (bus.req_size == 2'b11) ? SZ_WORD : bus.req_size;
    case (size_eff)
      SZ_BYTE: off_eff = bus.req_addr[1:0];
      SZ_HALF: off_eff = {bus.req_addr[1], 1'b0};
      default: off_eff = 2'b00;
    endcase
`ifdef MISALIGN_TRAP_EN
    fault = (bus.req_size == 2'b11)
         || ((bus.req_size == SZ_HALF) && bus.req_addr[0])
         || ((bus.req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00));
`else
    fault = 1'b0;
`endif
  end

  // Next-state logic
  always_comb begin : fsm_next
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (fault)                                   state_d = RSP;
          else if (bus.req_we && (size_eff == SZ_WORD)) state_d = WR;
          else                                         state_d = RD;
        end
      end
      RD:      if (rd_last) state_d = we_q ? WR : RSP;
      WR:      state_d = RSP;
      RSP:     if (bus.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with the state register.
  always_comb begin : fsm_outputs
    mem_cs_d     = (state_d == RD) || (state_d == WR);
    mem_oe_d     = (state_d == RD);
    mem_we_d     = (state_d == WR);
    resp_valid_d = (state_d == RSP);
    wait_cnt_d   = ((state_q == RD) && (state_d == RD)) ? wait_cnt_q + 3'd1 : 3'd0;
  end

  always_ff @(posedge clk or posedge rst) begin : fsm_state
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin : fsm_regs
    if (rst) begin
      mem_cs_q     <= 1'b0;
      mem_oe_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      wait_cnt_q   <= 3'd0;
    end else begin
      mem_cs_q     <= mem_cs_d;
      mem_oe_q     <= mem_oe_d;
      mem_we_q     <= mem_we_d;
      resp_valid_q <= resp_valid_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  always_comb begin : load_extract
    case (off_q)
      2'd0:    byte_val = bus.mem_dout[31:24];
      2'd1:    byte_val = bus.mem_dout[23:16];
      2'd2:    byte_val = bus.mem_dout[15:8];
      default: byte_val = bus.mem_dout[7:0];
    endcase
    half_val = off_q[1] ? bus.mem_dout[15:0] : bus.mem_dout[31:16];
    case (size_q)
      SZ_BYTE: load_val = {{24{signed_q & byte_val[7]}}, byte_val};
      SZ_HALF: load_val = {{16{signed_q & half_val[15]}}, half_val};
      default: load_val = bus.mem_dout;
    endcase
  end

  // Read-modify-write merge; bit-lane gi holds the byte at address offset 3-gi.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE_OFF = 2'(3 - gi);
      logic       lane_sel;
      logic [7:0] lane_data;

      always_comb begin
        case (size_q)
          SZ_BYTE: begin
            lane_sel  = (off_q == LANE_OFF);
            lane_data = wdata_q[7:0];
          end
          SZ_HALF: begin
            lane_sel  = (off_q[1] == LANE_OFF[1]);
            lane_data = wdata_q[8*(gi%2) +: 8];
          end
          default: begin
            lane_sel  = 1'b1;
            lane_data = wdata_q[8*gi +: 8];
          end
        endcase
      end

      assign merged[8*gi +: 8] = lane_sel ? lane_data : bus.mem_dout[8*gi +: 8];
    end
  endgenerate

  always_comb begin : datapath_next
    we_d         = we_q;
    size_d       = size_q;
    signed_d     = signed_q;
    off_d        = off_q;
    wdata_d      = wdata_q;
    mem_addr_d   = mem_addr_q;
    mem_din_d    = mem_din_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    if (accept) begin
      we_d         = bus.req_we;
      size_d       = size_eff;
      signed_d     = bus.req_signed;
      off_d        = off_eff;
      wdata_d      = bus.req_wdata;
      resp_rdata_d = 32'h0;
      resp_err_d   = fault;
      if (!fault) begin
        mem_addr_d = {bus.req_addr[31:2], 2'b00};
        if (bus.req_we && (size_eff == SZ_WORD)) mem_din_d = bus.req_wdata;
      end
    end else if (rd_last) begin
      if (we_q) mem_din_d    = merged;
      else      resp_rdata_d = load_val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin : datapath_regs
    if (rst) begin
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      signed_q     <= 1'b0;
      off_q        <= 2'b00;
      wdata_q      <= 32'h0;
      mem_addr_q   <= 32'h0;
      mem_din_q    <= 32'h0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      we_q         <= we_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      off_q        <= off_d;
      wdata_q      <= wdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_din_q    <= mem_din_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.mem_cs     = mem_cs_q;
  assign bus.mem_oe     = mem_oe_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_din    = mem_din_q;
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter SRAM_WAIT, default 0: extra cycles to hold the read strobe before capturing mem_dout (range 0-7).
REQ-002 clk  input  1  single clock, rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  1  upstream (EX stage) request present.
REQ-005 req_ready  output  1  unit accepts a request this cycle.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-008 req_signed  input  1  sign-extend load result.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-justified.
REQ-011 resp_valid  output  1  response present to WB stage.
REQ-012 resp_ready  input  1  WB stage consumes the response.
REQ-013 resp_rdata  output  32  load result, right-justified, extended.
REQ-014 resp_err  output  1  access fault (see Configuration).
REQ-015 mem_cs, mem_oe, mem_we  output  1 each  SRAM strobes, registered.
REQ-016 mem_addr  output  32  word address {addr[31:2],2'b00}, registered.
REQ-017 mem_din  output  32  SRAM write word, registered.
REQ-018 mem_dout  input  32  SRAM read word.

Function
REQ-019 The FSM SHALL have states IDLE, RD, WR, RSP; req_ready = 1 only in IDLE.
REQ-020 In IDLE, a request is accepted on the edge where req_valid=1; all request fields are latched on that edge.
REQ-021 Transitions on accept: load or sub-word store -> RD; word store -> WR; fault -> RSP.
REQ-022 RD SHALL drive cs=1, oe=1, we=0 for 1+SRAM_WAIT cycles, capture mem_dout on the last RD cycle, then go to WR (sub-word store) or RSP (load).
REQ-023 WR SHALL drive cs=1, oe=0, we=1 for exactly one cycle, then go to RSP.
REQ-024 IDLE and RSP SHALL drive cs=0, oe=0, we=0, so every SRAM access is delimited by a strobe edge.
REQ-025 Byte lanes are big-endian: lane at addr[1:0]=0 is bits 31:24; half at addr[1]=0 is bits 31:16.
REQ-026 Sub-word store SHALL write read word with only the addressed lane(s) replaced by req_wdata[7:0] / [15:0]; other lanes unchanged.
REQ-027 Load SHALL extract the addressed lane and zero-extend, or sign-extend when req_signed=1; word loads pass unchanged.
REQ-028 Store responses SHALL return resp_rdata=0.
REQ-029 RSP holds resp_valid=1 with stable resp_rdata/resp_err until resp_ready=1, then returns to IDLE; no new accept in the same cycle.
REQ-030 Latency (accept edge to resp_valid, SRAM_WAIT=0): word store 2 cycles, load 2, sub-word store 3, fault 1.
REQ-031 Requests arriving while not IDLE are ignored; upstream must hold req_valid until req_ready.

Reset
REQ-032 rst SHALL asynchronously force state IDLE and clear mem_cs, mem_oe, mem_we, mem_addr, mem_din, resp_valid, resp_rdata, resp_err, and wait counter to 0.
REQ-033 rst asserted mid-access SHALL abort it; a WR cycle cut by rst may or may not have written the SRAM; no response is issued.

Configuration
REQ-034 Macro MISALIGN_TRAP_EN defined: half with addr[0]=1, word with addr[1:0]!=0, or size 11 SHALL fault: no SRAM strobe, go directly to RSP with resp_err=1, resp_rdata=0.
REQ-035 MISALIGN_TRAP_EN undefined: low address bits SHALL be forced to alignment (half clears bit 0, word clears bits 1:0), size 11 treated as word, resp_err constantly 0.

Verification
REQ-036 Word store addr 0x100 data 0xDEADBEEF, then word load 0x100 -> mem_we pulse one cycle at 0x100, load resp_rdata=0xDEADBEEF, resp_valid 2 cycles after accept.
REQ-037 SRAM word 0x11223344 at 0x200; byte store 0xAA to 0x201 -> RD then WR, mem_din=0x11AA3344, resp 3 cycles after accept.
REQ-038 Word 0x80FF7F01 at 0x300: signed byte load 0x300 -> 0xFFFFFF80; unsigned half load 0x302 -> 0x00007F01; signed half 0x300 -> 0xFFFF80FF.
REQ-039 resp_ready held 0 for 4 cycles -> resp_valid, resp_rdata stable, req_ready=0, no SRAM strobes throughout.
REQ-040 With MISALIGN_TRAP_EN, word load at 0x102 -> resp_err=1 next cycle, mem_cs never asserted; without it -> reads 0x100, resp_err=0.
REQ-041 SRAM_WAIT=2, load -> oe held 3 cycles, resp 4 cycles after accept; rst asserted during RD -> all outputs 0 immediately, IDLE after release.
